// File: rtl/sobel_pkg.sv
// Shared widths and types for the Sobel edge path: gradient/magnitude widths,
// saturation ceiling and the raster coordinate carried by the window builder.
package sobel_pkg;

  localparam int COORD_W    = 16;
  localparam int GRAD_EXTRA = 3;
  localparam int MAG_EXTRA  = 4;

  // Signed gradient width: 4*(2^dw-1) in magnitude plus a sign bit.
  function automatic int grad_w(input int dw);
    return dw + GRAD_EXTRA;
  endfunction

  function automatic int mag_w(input int dw);
    return dw + MAG_EXTRA;
  endfunction

  function automatic int sat_max(input int dw);
    return (1 << dw) - 1;
  endfunction

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } win_coord_t;

endpackage

// File: rtl/line_delay.sv
// Fixed-length row buffer: data_o is the sample written DEPTH enables ago.
// Storage is a plain circular RAM that reset deliberately leaves untouched.
module line_delay #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Read-before-write on the same slot yields exactly DEPTH samples of delay.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  assign data_o = mem_q[ptr_q];

endmodule

// File: rtl/sobel_window.sv
// 3x3 neighbourhood builder: raster counters, two cascaded line delays, the
// window shift registers (stage S0) and the per-window valid/sof/eol flags.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DATA_WIDTH   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   pixel_i,
  input  logic                    valid_i,
  input  logic                    sof_i,
  output logic [9*DATA_WIDTH-1:0] win_o,
  output logic                    win_valid_o,
  output logic                    win_sof_o,
  output logic                    win_eol_o
);

  win_coord_t cnt_q;
  win_coord_t cnt_d;
  win_coord_t cur;

  logic [DATA_WIDTH-1:0] row   [3];
  logic [DATA_WIDTH-1:0] p_q   [3][3];
  logic                  win_valid_q;
  logic                  win_sof_q;
  logic                  win_eol_q;
  logic                  interior;

  // cnt_q is the coordinate the next accepted pixel will take; sof overrides it.
  always_comb begin
    cur = cnt_q;
    if (sof_i) begin
      cur = '0;
    end
    cnt_d = cnt_q;
    if (valid_i) begin
      cnt_d.x = cur.x + 1'b1;
      cnt_d.y = cur.y;
      if (cur.x == COORD_W'(LINE_WIDTH - 1)) begin
        cnt_d.x = '0;
        cnt_d.y = (cur.y == COORD_W'(FRAME_HEIGHT - 1)) ? '0 : cur.y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign row[2] = pixel_i;

  line_delay #(
    .DEPTH (LINE_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_ld1 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (valid_i),
    .data_i (pixel_i),
    .data_o (row[1])
  );

  line_delay #(
    .DEPTH (LINE_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_ld2 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (valid_i),
    .data_i (row[1]),
    .data_o (row[0])
  );

  // Column 2 is the newest sample of each row; data is gated by the flags.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      for (int r = 0; r < 3; r++) begin
        p_q[r][0] <= p_q[r][1];
        p_q[r][1] <= p_q[r][2];
        p_q[r][2] <= row[r];
      end
    end
  end

  assign interior = (cur.x >= COORD_W'(2)) && (cur.y >= COORD_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_eol_q   <= 1'b0;
    end else begin
      win_valid_q <= valid_i && interior;
      win_sof_q   <= valid_i && (cur.x == COORD_W'(2)) && (cur.y == COORD_W'(2));
      win_eol_q   <= valid_i && interior && (cur.x == COORD_W'(LINE_WIDTH - 1));
    end
  end

  always_comb begin
    win_o = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_o[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = p_q[r][c];
      end
    end
  end

  assign win_valid_o = win_valid_q;
  assign win_sof_o   = win_sof_q;
  assign win_eol_o   = win_eol_q;

endmodule

// File: rtl/sobel_filter.sv
// Sobel |Gx|+|Gy| edge filter: S0 window (sobel_window), S1 gradients, S2 magnitude.
// Define SOBEL_THRESHOLD_EN to binarize S2 against THRESHOLD instead of saturating.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DATA_WIDTH   = 6,
  parameter int THRESHOLD    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  data_valid,
  input  logic                  sof,
  output logic [DATA_WIDTH-1:0] edge_out,
  output logic                  edge_valid,
  output logic                  edge_sof,
  output logic                  edge_eol
);

  // Handshake: valid-only streaming. A beat moves when its valid is high at a
  // rising edge; there is no ready, so every edge_valid beat must be consumed.

  localparam int GW = grad_w(DATA_WIDTH);
  localparam int MW = mag_w(DATA_WIDTH);
  localparam logic [MW-1:0] SAT_MAG = MW'(sat_max(DATA_WIDTH));

  if (LINE_WIDTH < 3) begin : g_bad_line_width
    $error("sobel_filter: LINE_WIDTH must be at least 3");
  end
  if (FRAME_HEIGHT < 3) begin : g_bad_frame_height
    $error("sobel_filter: FRAME_HEIGHT must be at least 3");
  end
  if (THRESHOLD < 0) begin : g_bad_threshold
    $error("sobel_filter: THRESHOLD must be non-negative");
  end

  logic [9*DATA_WIDTH-1:0] win;
  logic                    win_valid;
  logic                    win_sof;
  logic                    win_eol;

  sobel_window #(
    .LINE_WIDTH   (LINE_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .pixel_i     (pixel_in),
    .valid_i     (data_valid),
    .sof_i       (sof),
    .win_o       (win),
    .win_valid_o (win_valid),
    .win_sof_o   (win_sof),
    .win_eol_o   (win_eol)
  );

  // ---------------- S1: gradients ----------------
  logic signed [GW-1:0] pe [3][3];
  logic signed [GW-1:0] gx_d;
  logic signed [GW-1:0] gy_d;
  logic signed [GW-1:0] gx_q;
  logic signed [GW-1:0] gy_q;
  logic                 s1_valid_q;
  logic                 s1_sof_q;
  logic                 s1_eol_q;

  // Zero-extended pixels keep the sums exact; 4*max fits without overflow.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pe[r][c] = {{(GW-DATA_WIDTH){1'b0}}, win[(r*3+c)*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    gx_d = (pe[0][2] + (pe[1][2] <<< 1) + pe[2][2])
         - (pe[0][0] + (pe[1][0] <<< 1) + pe[2][0]);
    gy_d = (pe[2][0] + (pe[2][1] <<< 1) + pe[2][2])
         - (pe[0][0] + (pe[0][1] <<< 1) + pe[0][2]);
  end

  always_ff @(posedge clk) begin
    gx_q <= gx_d;
    gy_q <= gy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
    end else begin
      s1_valid_q <= win_valid;
      s1_sof_q   <= win_valid && win_sof;
      s1_eol_q   <= win_valid && win_eol;
    end
  end

  // ---------------- S2: magnitude and output ----------------
  logic [GW-1:0]         ax;
  logic [GW-1:0]         ay;
  logic [MW-1:0]         mag;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] edge_out_d;
  logic                  edge_valid_d;
  logic                  edge_sof_d;
  logic                  edge_eol_d;
  logic [DATA_WIDTH-1:0] edge_out_q;
  logic                  edge_valid_q;
  logic                  edge_sof_q;
  logic                  edge_eol_q;

  always_comb begin
    ax  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag = {1'b0, ax} + {1'b0, ay};
`ifdef SOBEL_THRESHOLD_EN
    res = (mag >= MW'(THRESHOLD)) ? '1 : '0;
`else
    res = (mag > SAT_MAG) ? SAT_MAG[DATA_WIDTH-1:0] : mag[DATA_WIDTH-1:0];
`endif
    edge_out_d   = s1_valid_q ? res : '0;
    edge_valid_d = s1_valid_q;
    edge_sof_d   = s1_valid_q && s1_sof_q;
    edge_eol_d   = s1_valid_q && s1_eol_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_out_q   <= '0;
      edge_valid_q <= 1'b0;
      edge_sof_q   <= 1'b0;
      edge_eol_q   <= 1'b0;
    end else begin
      edge_out_q   <= edge_out_d;
      edge_valid_q <= edge_valid_d;
      edge_sof_q   <= edge_sof_d;
      edge_eol_q   <= edge_eol_d;
    end
  end

  assign edge_out   = edge_out_q;
  assign edge_valid = edge_valid_q;
  assign edge_sof   = edge_sof_q;
  assign edge_eol   = edge_eol_q;

endmodule
